read_port_arbiter: RTL and testbench



---
 rtl/read_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_read_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_port_arbiter.sv
// -----------------------------------------------------------------------------
// read_port_arbiter
//
// Shares one AXI read master port between an instruction-fetch requester (IM)
// and a data-load requester (DM). One single-beat read is in flight at a time.
// Ties are resolved round-robin, and after reset IM wins the first tie.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   im_req, im_addr          IM read request (level) and address
//   dm_req, dm_addr          DM read request (level) and address
//   im_rdata, dm_rdata       registered read data, one register per requester
//   im_stall, dm_stall       high while that requester's read is pending
//   AR*_M                    AXI read-address channel (ARREADY_M is an input)
//   R*_M                     AXI read-data channel (RREADY_M is an output)
// -----------------------------------------------------------------------------
module read_port_arbiter #(
    parameter logic [3:0] IM_ID = 4'b0000,
    parameter logic [3:0] DM_ID = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        im_req,
    input  logic [31:0] im_addr,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    output logic [31:0] im_rdata,
    output logic [31:0] dm_rdata,
    output logic        im_stall,
    output logic        dm_stall,

    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,

    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        owner_dm;   // owner of the current transaction: 0 = IM, 1 = DM
    logic        last_dm;    // requester served last: 0 = IM, 1 = DM
    logic [31:0] addr_q;     // address latched at grant
    logic        grant_dm;   // DM wins the grant taken in IDLE this cycle
    logic        any_req;
    logic [31:0] beat_data;  // RDATA_M with error responses forced to zero

    // Only one read is ever outstanding, so the returned ID carries no
    // information and is deliberately ignored.
    logic        unused_rid;
    assign unused_rid = ^RID_M;

    // Single-beat, 4-byte, INCR bursts only.
    assign ARLEN_M   = 4'd0;
    assign ARSIZE_M  = 3'd2;
    assign ARBURST_M = 2'd1;

    // A lone request always wins; on a tie the requester not served last wins.
    assign any_req   = im_req || dm_req;
    assign grant_dm  = dm_req && (!im_req || !last_dm);

    assign beat_data = (RRESP_M == 2'b00) ? RDATA_M : 32'd0;

    // Stall drops only in the single DONE cycle of the requester's own read,
    // so it rises combinationally together with a new request.
    assign im_stall  = im_req && !((state == DONE) && !owner_dm);
    assign dm_stall  = dm_req && !((state == DONE) &&  owner_dm);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and AXI channel outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ARVALID_M  = 1'b0;
        ARADDR_M   = 32'd0;
        ARID_M     = IM_ID;
        RREADY_M   = 1'b0;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                ARVALID_M = 1'b1;
                ARADDR_M  = addr_q;
                ARID_M    = owner_dm ? DM_ID : IM_ID;
                if (ARREADY_M) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                RREADY_M = 1'b1;
                if (RVALID_M && RLAST_M) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Grant bookkeeping and read-data capture
    // -------------------------------------------------------------------------
    // NOTE: the read-data registers are architecturally visible and must read
    // zero straight out of reset, so they are reset like control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_dm <= 1'b0;
            last_dm  <= 1'b1;
            addr_q   <= 32'd0;
            im_rdata <= 32'd0;
            dm_rdata <= 32'd0;
        end else begin
            if ((state == IDLE) && any_req) begin
                owner_dm <= grant_dm;
                addr_q   <= grant_dm ? dm_addr : im_addr;
            end

            if ((state == DATA) && RVALID_M) begin
                if (owner_dm) begin
                    dm_rdata <= beat_data;
                end else begin
                    im_rdata <= beat_data;
                end
                // Round-robin history moves on the edge that enters DONE.
                if (RLAST_M) begin
                    last_dm <= owner_dm;
                end
            end
        end
    end

endmodule

// File: tb/tb_read_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_read_port_arbiter
//
// Directed scenarios with literal expectations, then randomized requesters and
// a randomized AXI slave. A transaction-level reference model tracks the one
// in-flight read, and a compare process checks every DUT output against it on
// every falling clock edge.
// -----------------------------------------------------------------------------
module tb_read_port_arbiter;

    localparam logic [3:0] IM_ID = 4'b0000;
    localparam logic [3:0] DM_ID = 4'b0001;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] im_rdata;
    logic [31:0] dm_rdata;
    logic        im_stall;
    logic        dm_stall;
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M;
    logic        RVALID_M;
    logic        RREADY_M;

    int total = 0;
    int bad   = 0;

    read_port_arbiter #(.IM_ID(IM_ID), .DM_ID(DM_ID)) dut (
        .clk       (clk),
        .rst       (rst),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .im_rdata  (im_rdata),
        .dm_rdata  (dm_rdata),
        .im_stall  (im_stall),
        .dm_stall  (dm_stall),
        .ARID_M    (ARID_M),
        .ARADDR_M  (ARADDR_M),
        .ARLEN_M   (ARLEN_M),
        .ARSIZE_M  (ARSIZE_M),
        .ARBURST_M (ARBURST_M),
        .ARVALID_M (ARVALID_M),
        .ARREADY_M (ARREADY_M),
        .RID_M     (RID_M),
        .RDATA_M   (RDATA_M),
        .RRESP_M   (RRESP_M),
        .RLAST_M   (RLAST_M),
        .RVALID_M  (RVALID_M),
        .RREADY_M  (RREADY_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Reference model: one transaction record plus a one-cycle completion flag.
    // -------------------------------------------------------------------------
    logic        m_valid;      // a read has been granted and not yet finished
    logic        m_sent;       // its address has been accepted
    logic        m_fin;        // the read finished on the last edge
    logic        m_owner;      // 0 = IM, 1 = DM
    logic        m_last;       // last served: 0 = IM, 1 = DM
    logic [31:0] m_addr;
    logic [31:0] m_rd [2];
    logic        m_pick;

    assign m_pick = (im_req && dm_req) ? !m_last : dm_req;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_sent  <= 1'b0;
            m_fin   <= 1'b0;
            m_owner <= 1'b0;
            m_last  <= 1'b1;
            m_addr  <= 32'd0;
            m_rd[0] <= 32'd0;
            m_rd[1] <= 32'd0;
        end else if (m_fin) begin
            m_fin <= 1'b0;
        end else if (!m_valid) begin
            if (im_req || dm_req) begin
                m_valid <= 1'b1;
                m_sent  <= 1'b0;
                m_owner <= m_pick;
                m_addr  <= m_pick ? dm_addr : im_addr;
            end
        end else if (!m_sent) begin
            if (ARREADY_M) m_sent <= 1'b1;
        end else if (RVALID_M) begin
            m_rd[m_owner] <= (RRESP_M == 2'b00) ? RDATA_M : 32'd0;
            if (RLAST_M) begin
                m_valid <= 1'b0;
                m_fin   <= 1'b1;
                m_last  <= m_owner;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic exp_arv;
        exp_arv = m_valid && !m_sent;
        check("ARVALID_M", {31'd0, ARVALID_M}, {31'd0, exp_arv});
        check("ARADDR_M", ARADDR_M, exp_arv ? m_addr : 32'd0);
        check("ARID_M", {28'd0, ARID_M}, {28'd0, (exp_arv && m_owner) ? DM_ID : IM_ID});
        check("RREADY_M", {31'd0, RREADY_M}, {31'd0, m_valid && m_sent});
        check("im_stall", {31'd0, im_stall}, {31'd0, im_req && !(m_fin && !m_owner)});
        check("dm_stall", {31'd0, dm_stall}, {31'd0, dm_req && !(m_fin && m_owner)});
        check("im_rdata", im_rdata, m_rd[0]);
        check("dm_rdata", dm_rdata, m_rd[1]);
        check("ARLEN_M", {28'd0, ARLEN_M}, 32'd0);
        check("ARSIZE_M", {29'd0, ARSIZE_M}, 32'd2);
        check("ARBURST_M", {30'd0, ARBURST_M}, 32'd1);
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic im_served;
    logic dm_served;

    initial begin
        rst       = 1'b0;
        im_req    = 1'b0;
        im_addr   = 32'd0;
        dm_req    = 1'b0;
        dm_addr   = 32'd0;
        ARREADY_M = 1'b0;
        RID_M     = 4'd0;
        RDATA_M   = 32'd0;
        RRESP_M   = 2'b00;
        RLAST_M   = 1'b0;
        RVALID_M  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", {31'd0, ARVALID_M}, 32'd0);
        check("rst_rready", {31'd0, RREADY_M}, 32'd0);
        check("rst_im_rdata", im_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        tick();
        rst = 1'b1;

        // ---- Minimum-latency IM read --------------------------------------
        im_req = 1'b1; im_addr = 32'h0000_0040; ARREADY_M = 1'b1;
        @(negedge clk);                                       // cycle 0
        check("t1_c0_stall", {31'd0, im_stall}, 32'd1);
        check("t1_c0_arvalid", {31'd0, ARVALID_M}, 32'd0);
        tick();
        @(negedge clk);                                       // cycle 1
        check("t1_c1_arvalid", {31'd0, ARVALID_M}, 32'd1);
        check("t1_c1_araddr", ARADDR_M, 32'h0000_0040);
        check("t1_c1_arid", {28'd0, ARID_M}, 32'd0);
        tick();
        ARREADY_M = 1'b0; RVALID_M = 1'b1; RLAST_M = 1'b1;
        RDATA_M = 32'hDEAD_BEEF; RRESP_M = 2'b00;
        @(negedge clk);                                       // cycle 2
        check("t1_c2_rready", {31'd0, RREADY_M}, 32'd1);
        check("t1_c2_stall", {31'd0, im_stall}, 32'd1);
        tick();
        RVALID_M = 1'b0; RLAST_M = 1'b0;
        @(negedge clk);                                       // cycle 3
        check("t1_c3_stall", {31'd0, im_stall}, 32'd0);
        check("t1_c3_im_rdata", im_rdata, 32'hDEAD_BEEF);
        tick();
        im_req = 1'b0;

        // ---- Back-to-back ties after reset: IM, DM, IM, DM ---------------
        rst = 1'b0;
        #2;
        rst = 1'b1;
        im_req = 1'b1; dm_req = 1'b1; im_addr = 32'h80; dm_addr = 32'h200;
        ARREADY_M = 1'b1; RVALID_M = 1'b1; RLAST_M = 1'b1;
        RRESP_M = 2'b00; RDATA_M = 32'h1234_5678;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t2_arvalid", {31'd0, ARVALID_M}, {31'd0, (i % 4) == 1});
            check("t2_arid", {28'd0, ARID_M}, {31'd0, (i % 8) == 5});
            check("t2_araddr", ARADDR_M, ((i % 8) == 1) ? 32'h80 : (((i % 8) == 5) ? 32'h200 : 32'd0));
            check("t2_im_stall", {31'd0, im_stall}, {31'd0, (i % 8) != 3});
            check("t2_dm_stall", {31'd0, dm_stall}, {31'd0, (i % 8) != 7});
            if (i == 7) check("t2_dm_rdata", dm_rdata, 32'h1234_5678);
            tick();
        end

        // ---- DM read, ARREADY held off 5 cycles, SLVERR response ---------
        im_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h100;
        ARREADY_M = 1'b0; RVALID_M = 1'b0; RLAST_M = 1'b0;
        RRESP_M = 2'b10; RDATA_M = 32'hCAFE_F00D;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) ARREADY_M = 1'b1;
            @(negedge clk);
            check("t3_arvalid", {31'd0, ARVALID_M}, 32'd1);
            check("t3_araddr", ARADDR_M, 32'h100);
            check("t3_arid", {28'd0, ARID_M}, 32'd1);
        end
        tick();
        ARREADY_M = 1'b0; RVALID_M = 1'b1; RLAST_M = 1'b1;
        @(negedge clk);
        check("t3_rready", {31'd0, RREADY_M}, 32'd1);
        tick();
        RVALID_M = 1'b0; RLAST_M = 1'b0;
        @(negedge clk);
        check("t3_dm_stall", {31'd0, dm_stall}, 32'd0);
        check("t3_dm_rdata", dm_rdata, 32'd0);
        check("t3_im_rdata_hold", im_rdata, 32'h1234_5678);
        tick();
        dm_req = 1'b0; RRESP_M = 2'b00;

        // ---- Reset while waiting in DATA ----------------------------------
        im_req = 1'b1; im_addr = 32'h300; ARREADY_M = 1'b1;
        tick();
        tick();
        ARREADY_M = 1'b0;
        @(negedge clk);
        check("t4_rready_before", {31'd0, RREADY_M}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t4_arvalid", {31'd0, ARVALID_M}, 32'd0);
        check("t4_rready", {31'd0, RREADY_M}, 32'd0);
        check("t4_im_rdata", im_rdata, 32'd0);
        check("t4_dm_rdata", dm_rdata, 32'd0);
        check("t4_im_stall", {31'd0, im_stall}, 32'd1);
        im_req = 1'b0;
        tick();
        rst = 1'b1;

        // ---- Randomized traffic against the model ------------------------
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            im_served = im_req && !im_stall;
            dm_served = dm_req && !dm_stall;
            tick();
            if (im_req && !im_served) begin
                if ($urandom_range(0, 99) == 0) im_req = 1'b0;
            end else begin
                im_req  = ($urandom_range(0, 9) < 4);
                im_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (dm_req && !dm_served) begin
                if ($urandom_range(0, 99) == 0) dm_req = 1'b0;
            end else begin
                dm_req  = ($urandom_range(0, 9) < 4);
                dm_addr = $urandom & 32'hFFFF_FFFC;
            end
            ARREADY_M = ($urandom_range(0, 3) != 0);
            RVALID_M  = ($urandom_range(0, 1) != 0);
            RLAST_M   = ($urandom_range(0, 2) != 0);
            RRESP_M   = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            RDATA_M   = $urandom;
            RID_M     = 4'($urandom_range(0, 15));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
